// File: rtl/uart_rx_if.sv
// Receive-side byte handshake between the UART receiver and its consumer.
// The receiver (master) presents rx_data/out_valid. The consumer (slave)
// answers with out_ready.
interface uart_rx_if;
    logic [7:0] rx_data;
    logic       out_valid;
    logic       out_ready;

    modport master (
        output rx_data,
        output out_valid,
        input  out_ready
    );

    modport slave (
        input  rx_data,
        input  out_valid,
        output out_ready
    );
endinterface

// File: rtl/uart_rx.sv
// UART receiver, 8 data bits, no parity, 1 stop bit, 16x oversampling.
// The line is synchronized, sampled at bit centres by a free-running tick
// and assembled LSB first. Completed bytes are offered on a valid/ready
// handshake. A bad stop bit produces a frame_error pulse. A byte that
// arrives while the previous one is still unconsumed produces an overrun
// pulse.
module uart_rx #(
    parameter int CLK_FREQUENCY = 50_000_000,
    parameter int BAUD_RATE     = 115_200,
    // Only 16 is supported: the bit-centre arithmetic below assumes it.
    parameter int OVERSAMPLE    = 16
) (
    input  logic      clk,
    input  logic      rst,          // asynchronous, active low
    input  logic      rx,
    uart_rx_if.master out_if,
    output logic      frame_error,
    output logic      overrun,
    output logic      busy
);

    // Clocks per sample tick (floor). It must be at least 1.
    localparam int DIV   = CLK_FREQUENCY / (BAUD_RATE * OVERSAMPLE);
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_DATA      = 3'd2,
        S_STOP      = 3'd3,
        S_WAIT_HIGH = 3'd4
    } state_t;

    // Line synchronizer. Both flops rest at the idle level.
    logic             r_rx_meta;
    logic             r_rx_sync;

    // Sample tick generator.
    logic [DIV_W-1:0] r_div_cnt;
    logic             w_tick;

    // FSM and datapath.
    state_t           r_state;
    state_t           w_next_state;
    logic [3:0]       r_tick_cnt;
    logic [2:0]       r_bit_idx;
    logic [7:0]       r_shift;

    // Datapath controls decoded from the state.
    logic             w_cnt_clr;
    logic             w_cnt_inc;
    logic             w_idx_clr;
    logic             w_idx_inc;
    logic             w_shift_en;
    logic             w_byte_done;
    logic             w_frame_err;

    // Output stage.
    logic [7:0]       r_rx_data;
    logic             r_out_valid;
    logic             r_frame_error;
    logic             r_overrun;
    logic             r_busy;
    logic             w_xfer;
    logic             w_load;

    // Two-flop synchronizer for the asynchronous serial line.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rx_sync <= r_rx_meta;
        end
    end

    // Free-running sample-tick divider. It is not realigned to frames.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_div_cnt <= '0;
        end else if (r_div_cnt == DIV_LAST) begin
            r_div_cnt <= '0;
        end else begin
            r_div_cnt <= r_div_cnt + DIV_W'(1);
        end
    end

    assign w_tick = (r_div_cnt == DIV_LAST);

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM next-state logic.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (!r_rx_sync) begin
                    w_next_state = S_START;
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            S_START: begin
                // Re-check the line at the middle of the start bit. A high
                // line here means a glitch, so the FSM goes back to idle.
                if (w_tick && (r_tick_cnt == 4'd7)) begin
                    w_next_state = r_rx_sync ? S_IDLE : S_DATA;
                end else begin
                    w_next_state = S_START;
                end
            end
            S_DATA: begin
                if (w_tick && (r_tick_cnt == 4'd15) && (r_bit_idx == 3'd7)) begin
                    w_next_state = S_STOP;
                end else begin
                    w_next_state = S_DATA;
                end
            end
            S_STOP: begin
                // A low stop bit means the line may be held in break, so
                // the FSM waits for it to go high before hunting again.
                if (w_tick && (r_tick_cnt == 4'd15)) begin
                    w_next_state = r_rx_sync ? S_IDLE : S_WAIT_HIGH;
                end else begin
                    w_next_state = S_STOP;
                end
            end
            S_WAIT_HIGH: begin
                if (r_rx_sync) begin
                    w_next_state = S_IDLE;
                end else begin
                    w_next_state = S_WAIT_HIGH;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // FSM output decode: datapath strobes and completion events.
    always_comb begin
        w_cnt_clr   = 1'b0;
        w_cnt_inc   = 1'b0;
        w_idx_clr   = 1'b0;
        w_idx_inc   = 1'b0;
        w_shift_en  = 1'b0;
        w_byte_done = 1'b0;
        w_frame_err = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_cnt_clr = 1'b1;
                w_idx_clr = 1'b1;
            end
            S_START: begin
                if (w_tick) begin
                    if (r_tick_cnt == 4'd7) begin
                        w_cnt_clr = 1'b1;
                        w_idx_clr = 1'b1;
                    end else begin
                        w_cnt_inc = 1'b1;
                    end
                end else begin
                    w_cnt_inc = 1'b0;
                end
            end
            S_DATA: begin
                if (w_tick) begin
                    if (r_tick_cnt == 4'd15) begin
                        w_cnt_clr  = 1'b1;
                        w_shift_en = 1'b1;
                        w_idx_inc  = 1'b1;
                    end else begin
                        w_cnt_inc = 1'b1;
                    end
                end else begin
                    w_cnt_inc = 1'b0;
                end
            end
            S_STOP: begin
                if (w_tick) begin
                    if (r_tick_cnt == 4'd15) begin
                        w_cnt_clr = 1'b1;
                        if (r_rx_sync) begin
                            w_byte_done = 1'b1;
                        end else begin
                            w_frame_err = 1'b1;
                        end
                    end else begin
                        w_cnt_inc = 1'b1;
                    end
                end else begin
                    w_cnt_inc = 1'b0;
                end
            end
            S_WAIT_HIGH: begin
                w_cnt_clr = 1'b1;
            end
            default: begin
                w_cnt_clr = 1'b1;
                w_idx_clr = 1'b1;
            end
        endcase
    end

    // Tick counter, bit index and LSB-first shift register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tick_cnt <= 4'd0;
            r_bit_idx  <= 3'd0;
            r_shift    <= 8'h00;
        end else begin
            if (w_cnt_clr) begin
                r_tick_cnt <= 4'd0;
            end else if (w_cnt_inc) begin
                r_tick_cnt <= r_tick_cnt + 4'd1;
            end else begin
                r_tick_cnt <= r_tick_cnt;
            end

            if (w_idx_clr) begin
                r_bit_idx <= 3'd0;
            end else if (w_idx_inc) begin
                r_bit_idx <= r_bit_idx + 3'd1;
            end else begin
                r_bit_idx <= r_bit_idx;
            end

            if (w_shift_en) begin
                r_shift <= {r_rx_sync, r_shift[7:1]};
            end else begin
                r_shift <= r_shift;
            end
        end
    end

    // The consumer takes the current byte this cycle.
    assign w_xfer = r_out_valid & out_if.out_ready;
    // A new byte is accepted only if the holding register is free or is
    // being emptied this cycle. Otherwise the old byte wins.
    assign w_load = w_byte_done & (~r_out_valid | w_xfer);

    // Output holding register, handshake state and event pulses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rx_data     <= 8'h00;
            r_out_valid   <= 1'b0;
            r_frame_error <= 1'b0;
            r_overrun     <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            if (w_load) begin
                r_rx_data   <= r_shift;
                r_out_valid <= 1'b1;
            end else if (w_xfer) begin
                r_rx_data   <= r_rx_data;
                r_out_valid <= 1'b0;
            end else begin
                r_rx_data   <= r_rx_data;
                r_out_valid <= r_out_valid;
            end
            r_overrun     <= w_byte_done & ~w_load;
            r_frame_error <= w_frame_err;
            // Registered copy of the state decode, so busy follows the
            // state register on the same edge.
            r_busy        <= (w_next_state != S_IDLE);
        end
    end

    assign out_if.rx_data   = r_rx_data;
    assign out_if.out_valid = r_out_valid;
    assign frame_error      = r_frame_error;
    assign overrun          = r_overrun;
    assign busy             = r_busy;

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx at 16 clocks per bit (DIV = 1).
// Inputs change 1 time unit after a rising edge. Outputs are observed on
// the falling edge.
module tb_uart_rx;

    localparam int CLK_HZ   = 1_600_000;
    localparam int BAUD     = 100_000;
    localparam int BIT_CLKS = 16;

    logic clk = 1'b0;
    logic rst;
    logic rx;
    logic frame_error;
    logic overrun;
    logic busy;

    uart_rx_if u_if ();

    uart_rx #(
        .CLK_FREQUENCY (CLK_HZ),
        .BAUD_RATE     (BAUD),
        .OVERSAMPLE    (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rx          (rx),
        .out_if      (u_if),
        .frame_error (frame_error),
        .overrun     (overrun),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int n_xfer   = 0;
    int n_fe     = 0;
    int n_ovr    = 0;
    logic saw_busy = 1'b0;

    logic [7:0] exp_q[$];

    // Counts one comparison and reports it if it does not match.
    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: pops a byte on every transfer and checks pulse
    // widths and the hold behaviour.
    logic       prev_fe   = 1'b0;
    logic       prev_ovr  = 1'b0;
    logic       prev_hold = 1'b0;
    logic       prev_xfer = 1'b0;
    logic [7:0] prev_data = 8'h00;
    logic [7:0] exp_b;

    always @(negedge clk) begin
        if (rst) begin
            if (prev_hold) begin
                check_val("hold_valid", 32'(u_if.out_valid), 32'd1);
                check_val("hold_data", 32'(u_if.rx_data), 32'(prev_data));
            end
            if (prev_xfer) begin
                check_val("valid_fall", 32'(u_if.out_valid), 32'd0);
            end
            if (u_if.out_valid && u_if.out_ready) begin
                n_xfer++;
                if (exp_q.size() == 0) begin
                    check_val("unexpected_byte", 32'(exp_q.size()), 32'd1);
                end else begin
                    exp_b = exp_q.pop_front();
                    check_val("rx_data", 32'(u_if.rx_data), 32'(exp_b));
                end
            end
            if (frame_error) begin
                n_fe++;
                check_val("fe_width", 32'(prev_fe), 32'd0);
            end
            if (overrun) begin
                n_ovr++;
                check_val("ovr_width", 32'(prev_ovr), 32'd0);
            end
            if (busy) begin
                saw_busy = 1'b1;
            end
        end
        prev_fe   = rst & frame_error;
        prev_ovr  = rst & overrun;
        prev_hold = rst & u_if.out_valid & ~u_if.out_ready;
        prev_xfer = rst & u_if.out_valid & u_if.out_ready;
        prev_data = u_if.rx_data;
    end

    task automatic clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input logic b);
        rx = b;
        clks(BIT_CLKS);
    endtask

    task automatic send_byte(input logic [7:0] d, input logic stop_bit);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) begin
            drive_bit(d[i]);
        end
        drive_bit(stop_bit);
    endtask

    // Waits, with a bound, for every expected byte to be consumed.
    task automatic wait_drain();
        for (int i = 0; i < 64 && exp_q.size() != 0; i++) begin
            clks(1);
        end
        check_val("drain", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_rx_data"}, 32'(u_if.rx_data), 32'h00);
        check_val({tag, "_valid"}, 32'(u_if.out_valid), 32'd0);
        check_val({tag, "_fe"}, 32'(frame_error), 32'd0);
        check_val({tag, "_ovr"}, 32'(overrun), 32'd0);
        check_val({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    logic [7:0] part_byte;

    initial begin
        rst            = 1'b1;
        rx             = 1'b1;
        u_if.out_ready = 1'b0;
        #3;
        rst = 1'b0;
        #1;
        check_reset_outputs("reset");
        clks(4);
        rst = 1'b1;
        clks(20);

        // Clean frame with the consumer always ready.
        u_if.out_ready = 1'b1;
        exp_q.push_back(8'hA5);
        send_byte(8'hA5, 1'b1);
        wait_drain();
        clks(2);
        check_val("a5_busy_low", 32'(busy), 32'd0);
        check_val("a5_no_fe", 32'(n_fe), 32'd0);
        check_val("a5_xfers", 32'(n_xfer), 32'd1);

        // Short low glitch is rejected at the mid-start check.
        saw_busy = 1'b0;
        rx = 1'b0;
        clks(4);
        rx = 1'b1;
        clks(30);
        check_val("glitch_saw_busy", 32'(saw_busy), 32'd1);
        check_val("glitch_busy", 32'(busy), 32'd0);
        check_val("glitch_valid", 32'(u_if.out_valid), 32'd0);
        check_val("glitch_xfers", 32'(n_xfer), 32'd1);

        // Bad stop bit, then the line is held low: no new frame may start.
        send_byte(8'h3C, 1'b0);
        clks(40);
        check_val("fe_count", 32'(n_fe), 32'd1);
        check_val("fe_valid", 32'(u_if.out_valid), 32'd0);
        check_val("fe_wait_busy", 32'(busy), 32'd1);
        check_val("fe_xfers", 32'(n_xfer), 32'd1);
        rx = 1'b1;
        clks(20);
        check_val("fe_recover_busy", 32'(busy), 32'd0);
        exp_q.push_back(8'h42);
        send_byte(8'h42, 1'b1);
        wait_drain();
        check_val("x42_xfers", 32'(n_xfer), 32'd2);

        // Overrun: the second byte is dropped while the first is held.
        u_if.out_ready = 1'b0;
        exp_q.push_back(8'h11);
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        clks(4);
        check_val("ovr_count", 32'(n_ovr), 32'd1);
        check_val("ovr_valid", 32'(u_if.out_valid), 32'd1);
        check_val("ovr_data", 32'(u_if.rx_data), 32'h11);
        u_if.out_ready = 1'b1;
        wait_drain();
        clks(2);
        check_val("ovr_valid_fall", 32'(u_if.out_valid), 32'd0);
        check_val("ovr_xfers", 32'(n_xfer), 32'd3);

        // Reset in the middle of data bit 4 of 0x99.
        part_byte = 8'h99;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) begin
            drive_bit(part_byte[i]);
        end
        rx = part_byte[4];
        clks(8);
        rst = 1'b0;
        #1;
        check_reset_outputs("midrst");
        rx = 1'b1;
        clks(5);
        rst = 1'b1;
        clks(20);
        check_val("midrst_busy", 32'(busy), 32'd0);
        exp_q.push_back(8'h5A);
        send_byte(8'h5A, 1'b1);
        wait_drain();
        check_val("x5a_no_fe", 32'(n_fe), 32'd1);
        check_val("x5a_xfers", 32'(n_xfer), 32'd4);

        // Back-to-back frames with no idle time between them.
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hFF);
        send_byte(8'h00, 1'b1);
        send_byte(8'hFF, 1'b1);
        wait_drain();
        clks(10);
        check_val("b2b_xfers", 32'(n_xfer), 32'd6);
        check_val("b2b_no_fe", 32'(n_fe), 32'd1);
        check_val("b2b_no_ovr", 32'(n_ovr), 32'd1);
        check_val("b2b_busy", 32'(busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
